// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad command scheduler: button bit positions,
// command codes and the fixed arbitration priority.
// Latency: n/a (constants and combinational helpers only). Backpressure: n/a.
package gamepad_pkg;

  // Bit positions in the decoded 12-bit button vector
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_MODE  = 11;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NONE  = 4'd0;
  localparam cmd_t CMD_UP    = 4'd1;
  localparam cmd_t CMD_DOWN  = 4'd2;
  localparam cmd_t CMD_LEFT  = 4'd3;
  localparam cmd_t CMD_RIGHT = 4'd4;
  localparam cmd_t CMD_A     = 4'd5;
  localparam cmd_t CMD_B     = 4'd6;
  localparam cmd_t CMD_C     = 4'd7;
  localparam cmd_t CMD_START = 4'd8;

  // Highest-priority command among the set bits: START > A > B > C > UP >
  // DOWN > LEFT > RIGHT. X, Y, Z and Mode never map to a command.
  function automatic cmd_t prio_cmd(input logic [11:0] v);
    cmd_t c;
    c = CMD_NONE;
    if      (v[BTN_START]) c = CMD_START;
    else if (v[BTN_A])     c = CMD_A;
    else if (v[BTN_B])     c = CMD_B;
    else if (v[BTN_C])     c = CMD_C;
    else if (v[BTN_UP])    c = CMD_UP;
    else if (v[BTN_DOWN])  c = CMD_DOWN;
    else if (v[BTN_LEFT])  c = CMD_LEFT;
    else if (v[BTN_RIGHT]) c = CMD_RIGHT;
    return c;
  endfunction

  // Highest-priority direction among the set bits (used for auto-repeat).
  function automatic cmd_t dir_cmd(input logic [11:0] v);
    cmd_t c;
    c = CMD_NONE;
    if      (v[BTN_UP])    c = CMD_UP;
    else if (v[BTN_DOWN])  c = CMD_DOWN;
    else if (v[BTN_LEFT])  c = CMD_LEFT;
    else if (v[BTN_RIGHT]) c = CMD_RIGHT;
    return c;
  endfunction

endpackage

// File: rtl/gamepad_command_scheduler_if.sv
// Command handshake between the scheduler (master) and the robot motion core.
// Latency: n/a (wires only). Backpressure: cmd_ready low holds the head command.
// Signals: cmd_valid/cmd_code from master, cmd_ready from slave.
interface gamepad_command_scheduler_if;
  logic              cmd_valid;
  gamepad_pkg::cmd_t cmd_code;
  logic              cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with push/pop, full/empty, occupancy and drop flag.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push while full is dropped (drop_o) unless a pop frees a slot.
// Ports: clk, rst (async, active high), push_i/push_dat_i, pop_i,
//        head_dat_o (0 when empty), empty_o, full_o, count_o, drop_o.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // A pop on empty is ignored, so push+pop on empty only pushes.
  assign pop_ok  = pop_i & ~empty_o;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & full_o & ~pop_ok;

  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/gamepad_command_scheduler.sv
// Frame-rate gamepad sampler: debounce, press detect, priority arbitration,
// auto-repeat, 4-entry command queue. Latency: decided at tick edge T, queued
// at T+1. Backpressure: cmd_ready low holds the head; full queue drops + overflow.
// Ports: clk, Reset (async, active high), vga_vs (async), Botoes[11:0],
//        clear_ovf, cmd (master handshake), fifo_count[2:0], overflow.
module gamepad_command_scheduler
  import gamepad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_FRAMES   = 15,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               Reset,
  input  logic                               vga_vs,
  input  logic [11:0]                        Botoes,
  input  logic                               clear_ovf,
  gamepad_command_scheduler_if.master        cmd,
  output logic [2:0]                         fifo_count,
  output logic                               overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        vs_s1_q, vs_s2_q, vs_prev_q;
  logic        tick;
  logic [11:0] last_sample_q, last_sample_d;
  logic [11:0] stable_q, stable_d;
  logic [3:0]  stab_cnt_q, stab_cnt_d;
  cmd_t        held_q, held_d;
  logic [5:0]  rep_cnt_q, rep_cnt_d;
  logic        push_q, push_d;
  cmd_t        push_code_q, push_code_d;
  logic        overflow_q;
  cmd_t        press_cmd;

  logic          fifo_empty, fifo_full, fifo_drop, pop;
  logic [CW-1:0] fifo_cnt;
  cmd_t          head_code;

  // Falling edge of the synchronised vsync marks one frame.
  assign tick = vs_prev_q & ~vs_s2_q;

  always_comb begin
    last_sample_d = last_sample_q;
    stable_d      = stable_q;
    stab_cnt_d    = stab_cnt_q;
    held_d        = held_q;
    rep_cnt_d     = rep_cnt_q;
    push_d        = 1'b0;
    push_code_d   = CMD_NONE;
    press_cmd     = CMD_NONE;
    if (tick) begin
      if (Botoes == last_sample_q) begin
        if (stab_cnt_q < 4'(DEBOUNCE_FRAMES)) stab_cnt_d = stab_cnt_q + 4'd1;
      end else begin
        stab_cnt_d    = 4'd1;
        last_sample_d = Botoes;
      end
      if (stab_cnt_d >= 4'(DEBOUNCE_FRAMES)) stable_d = Botoes;

      press_cmd = prio_cmd(stable_d & ~stable_q);

      held_d = dir_cmd(stable_d);
      if (held_d == held_q && held_d != CMD_NONE) rep_cnt_d = rep_cnt_q + 6'd1;
      else                                        rep_cnt_d = 6'd0;

      // Press edge wins over a repeat falling in the same frame; the repeat
      // period restarts either way.
      if (rep_cnt_d == 6'(REPEAT_FRAMES)) begin
        rep_cnt_d   = 6'd0;
        push_d      = 1'b1;
        push_code_d = held_d;
      end
      if (press_cmd != CMD_NONE) begin
        push_d      = 1'b1;
        push_code_d = press_cmd;
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      vs_s1_q       <= 1'b1;
      vs_s2_q       <= 1'b1;
      vs_prev_q     <= 1'b1;
      last_sample_q <= '0;
      stable_q      <= '0;
      stab_cnt_q    <= '0;
      held_q        <= CMD_NONE;
      rep_cnt_q     <= '0;
      push_q        <= 1'b0;
      push_code_q   <= CMD_NONE;
      overflow_q    <= 1'b0;
    end else begin
      vs_s1_q       <= vga_vs;
      vs_s2_q       <= vs_s1_q;
      vs_prev_q     <= vs_s2_q;
      last_sample_q <= last_sample_d;
      stable_q      <= stable_d;
      stab_cnt_q    <= stab_cnt_d;
      held_q        <= held_d;
      rep_cnt_q     <= rep_cnt_d;
      push_q        <= push_d;
      push_code_q   <= push_code_d;
      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (fifo_drop)      overflow_q <= 1'b1;
      else if (clear_ovf) overflow_q <= 1'b0;
    end
  end

  assign pop = ~fifo_empty & cmd.cmd_ready;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk        (clk),
    .rst        (Reset),
    .push_i     (push_q),
    .push_dat_i (push_code_q),
    .pop_i      (pop),
    .head_dat_o (head_code),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (fifo_cnt),
    .drop_o     (fifo_drop)
  );

  assign cmd.cmd_valid = ~fifo_empty;
  assign cmd.cmd_code  = head_code;
  assign fifo_count    = 3'(fifo_cnt);
  assign overflow      = overflow_q;

endmodule

// File: doc/gamepad_command_scheduler.md
Name: gamepad_command_scheduler

Overview:
Sits between the 6-button gamepad reader and the pipe-cleaning robot motion core.
- Samples the 12-bit decoded button vector once per video frame, on the falling edge of vga_vs.
- Debounces the vector and detects new presses.
- Arbitrates simultaneous presses by fixed priority and auto-repeats held directions.
- Queues the resulting command codes in a 4-entry FIFO, drained by the robot core over a valid/ready handshake.

Parameters:
DEBOUNCE_FRAMES, 2, consecutive identical frame samples needed before the stable vector updates (range 1..15).
REPEAT_FRAMES, 15, frames a direction must stay held before auto-repeat; also the repeat period (range 2..63).
FIFO_DEPTH, 4, command queue depth (power of two, at least 2).

Ports:
clk  input  1  system clock; all logic on posedge.
Reset  input  1  asynchronous, active-high reset.
vga_vs  input  1  VGA vertical sync, asynchronous to internal logic.
Botoes  input  12  active-high button vector from the gamepad reader: [0]Up [1]Down [2]Left [3]Right [4]A [5]B [6]C [7]X [8]Y [9]Z [10]Start [11]Mode.
cmd_ready  input  1  robot core accepts the head command.
clear_ovf  input  1  single-cycle pulse; clears overflow.
cmd_valid  output  1  FIFO is non-empty.
cmd_code  output  4  head command; 0 when empty.
fifo_count  output  3  number of queued entries (0..FIFO_DEPTH).
overflow  output  1  sticky flag: a command was dropped because the FIFO was full.

Behaviour:
- Reset, asynchronous: sync FFs = 1, sample/stable vectors = 0, counters = 0, FIFO empty, cmd_valid = 0, cmd_code = 0, fifo_count = 0, overflow = 0.
- Frame tick: vga_vs passes through a 2-FF synchronizer. tick = previous synced value AND NOT current synced value, a one-cycle pulse. All frame logic below advances only in the tick cycle T.
- Debounce:
  - If Botoes equals last_sample, stab_cnt increments, saturating at DEBOUNCE_FRAMES. Otherwise stab_cnt = 1 and last_sample = Botoes.
  - When the updated stab_cnt is at least DEBOUNCE_FRAMES, stable <= Botoes.
  - pressed = new_stable AND NOT old_stable.
- Command codes:
  - 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 A, 6 B, 7 C, 8 START.
  - X, Y, Z and Mode never generate commands.
- Arbitration:
  - Priority is START > A > B > C > UP > DOWN > LEFT > RIGHT.
  - At most one command is generated per tick: the highest-priority pressed bit. Lower-priority simultaneous presses are discarded, not deferred.
- Auto-repeat:
  - held_dir = the highest-priority direction bit set in new_stable.
  - If held_dir is unchanged and non-zero, rep_cnt increments. Otherwise rep_cnt = 0.
  - When rep_cnt reaches REPEAT_FRAMES, emit held_dir's code and set rep_cnt = 0.
  - A press edge in the same tick wins over a repeat; only one command is emitted.
- Latency: a command decided at tick edge T is pushed at edge T+1. cmd_valid is high after T+1 if the FIFO was empty.
- FIFO:
  - Registered pointers; cmd_code = mem[rd_ptr].
  - Pop when cmd_valid && cmd_ready.
  - Push is accepted if not full, or if full with a pop in the same cycle; count is unchanged in that case.
  - Push while full without a pop drops the command and sets overflow.
  - A pop on empty is ignored.
  - Simultaneous push and pop on empty: push only; the new entry appears next cycle.
- overflow: set has priority over clear_ovf in the same cycle. It is cleared only by clear_ovf or Reset.
- Reset mid-frame: the FIFO is flushed and the next frame restarts debounce from zero, so a held button re-emits its press after DEBOUNCE_FRAMES ticks.

Decomposition:
- Shared package gamepad_pkg holds:
  - button index constants BTN_UP..BTN_MODE;
  - command code constants CMD_NONE..CMD_START, 4-bit;
  - the priority order.
- Sub-module cmd_fifo: parameterized synchronous FIFO with push/pop/full/empty/count, asynchronous active-high Reset, same clk.
- Debounce, arbitration and repeat logic stay in the top module.

Test Plan:
- Hold Botoes = 12'h010 (A) across 3 vga_vs falling edges, cmd_ready = 1 -> exactly one cmd_code = 5 pulse with cmd_valid for 1 cycle, after the second tick; no repeat.
- Botoes = 12'h411 (Start + A + Up) stable for 2 ticks -> single command 8; A and Up are never emitted.
- Hold Up (12'h001) for 2+15+15 ticks -> codes 1, 1, 1 at ticks 2, 17 and 32.
- cmd_ready = 0; produce 5 distinct presses over 10 ticks -> fifo_count saturates at 4, overflow = 1, head remains the first code. Then clear_ovf -> overflow = 0.
- With the FIFO full, a push and a pop in the same cycle -> fifo_count stays 4, the new code lands at the tail, overflow stays 0.
- Assert Reset asynchronously mid-frame with 2 entries queued -> cmd_valid = 0 and fifo_count = 0 immediately. A held A re-emits 5 after 2 ticks.
